arb_mux: RTL and testbench
==========================

ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 4, number of input channels; any integer >= 1, not restricted to powers of 2.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, bits per channel.
REQ-003 SHALL have parameter ARB_MODE, default 1; 0 = fixed priority, lowest index wins; 1 = round-robin.
REQ-004 SHALL define local SEL_W = max(1, clog2(NUM_INPUTS)).
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 in_data  input  NUM_INPUTS*DATA_WIDTH  channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-008 in_valid  input  NUM_INPUTS  per-channel valid.
REQ-009 in_ready  output  NUM_INPUTS  per-channel ready, combinational, at most one bit set (one-hot or zero).
REQ-010 out_data  output  DATA_WIDTH  registered selected data.
REQ-011 out_valid  output  1  registered output valid.
REQ-012 out_ready  input  1  downstream ready.
REQ-013 out_sel  output  SEL_W  registered index of the channel that supplied out_data.

Function
REQ-014 SHALL compute load = !out_valid || out_ready each cycle.
REQ-015 SHALL select winner w among asserted in_valid bits; ARB_MODE=0: lowest asserted index; ARB_MODE=1: first asserted index scanning upward from ptr, wrapping NUM_INPUTS-1 -> 0.
REQ-016 SHALL drive in_ready[w]=1 only when load=1, rst=0 and in_valid[w]=1; all other in_ready bits 0.
REQ-017 Transfer on channel k SHALL occur iff in_valid[k] && in_ready[k] at a rising edge.
REQ-018 On transfer, SHALL register out_data <= channel w data, out_sel <= w, out_valid <= 1; latency one cycle, throughput one word per cycle.
REQ-019 When load=1 and no in_valid asserted, SHALL set out_valid <= 0; out_data and out_sel hold their values.
REQ-020 When out_valid=1 and out_ready=0, out_data, out_sel, out_valid SHALL hold stable and all in_ready SHALL be 0.
REQ-021 Simultaneous out_ready=1 and new transfer SHALL replace the output in the same edge with no bubble.
REQ-022 ARB_MODE=1: on each transfer ptr <= w+1, wrapping from NUM_INPUTS-1 to 0; ptr unchanged when no transfer; ptr width SEL_W.
REQ-023 ARB_MODE=0: ptr SHALL remain 0 and has no effect.
REQ-024 Round-robin SHALL guarantee a continuously valid channel is granted within NUM_INPUTS transfers.
REQ-025 NUM_INPUTS=1: SHALL behave as a single registered valid/ready stage with out_sel constant 0.
REQ-026 Non-power-of-2 NUM_INPUTS: ptr and out_sel SHALL never take values >= NUM_INPUTS.
REQ-027 No data SHALL be duplicated or dropped: each accepted word appears on out_data exactly once with out_valid && out_ready.

Reset
REQ-028 While rst=1 at an edge: out_valid <= 0, out_data <= 0, out_sel <= 0, ptr <= 0.
REQ-029 While rst=1, in_ready SHALL be all 0; no transfer occurs.
REQ-030 Reset mid-operation SHALL discard the held output word; first grant after reset in ARB_MODE=1 starts scan at channel 0.

Verification
REQ-031 NUM_INPUTS=4, ARB_MODE=1, all in_valid=1, out_ready=1, data k=0x10+k -> out_sel 0,1,2,3,0,... on consecutive cycles, out_data 0x10,0x11,0x12,0x13,0x10.
REQ-032 ARB_MODE=0, in_valid=4'b1010, out_ready=1 -> in_ready=4'b0010 every cycle, out_sel=1 repeatedly, channel 3 starved.
REQ-033 Output held: transfer 0xA5 from channel 2, then out_ready=0 for 5 cycles -> out_data=0xA5, out_sel=2, out_valid=1 stable, in_ready=0000; release -> next word accepted same edge.
REQ-034 NUM_INPUTS=3, ARB_MODE=1, in_valid=3'b111 -> out_sel sequence 0,1,2,0; ptr never reaches 3.
REQ-035 Assert rst with out_valid=1 and ptr=2 -> next cycle out_valid=0, out_data=0, out_sel=0; after release with all valid, first grant is channel 0.
REQ-036 Random in_valid/out_ready, 10k cycles, scoreboard per channel -> no loss, no duplication, in-order per channel, in_ready always one-hot or zero.

Source files
------------

// File: rtl/arb_mux.sv
// arb_mux -- N-input arbiter feeding a single registered valid/ready output stage.
//
// Ports
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset
//   in_data    NUM_INPUTS packed words, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready, combinational, one-hot or zero
//   out_data   registered data of the granted channel
//   out_valid  registered output valid
//   out_ready  downstream ready
//   out_sel    registered index of the channel that supplied out_data
//
// ARB_MODE 0: fixed priority, lowest index wins.
// ARB_MODE 1: round-robin, scan upward from ptr and wrap.

// Per-channel slice: flags requests at or above the round-robin pointer and
// decodes this channel's ready from the shared winner index.
module arb_mux_lane #(
   parameter int IDX   = 0,
   parameter int SEL_W = 1
) (
   input  logic             valid,
   input  logic [SEL_W-1:0] ptr,
   input  logic [SEL_W-1:0] win,
   input  logic             grant,
   output logic             hi_req,
   output logic             ready
);
   localparam logic [SEL_W-1:0] ME = SEL_W'(IDX);

   assign hi_req = valid && (ME >= ptr);
   assign ready  = grant && (win == ME);
endmodule

module arb_mux #(
   parameter int NUM_INPUTS = 4,
   parameter int DATA_WIDTH = 8,
   parameter int ARB_MODE   = 1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
   input  logic [NUM_INPUTS-1:0]            in_valid,
   output logic [NUM_INPUTS-1:0]            in_ready,
   output logic [DATA_WIDTH-1:0]            out_data,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [((NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1)-1:0] out_sel
);
   localparam int SEL_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
   localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_INPUTS - 1);

   logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] lane_data;
   logic [NUM_INPUTS-1:0]                 hi_req;
   logic [SEL_W-1:0]                      ptr;
   logic [SEL_W-1:0]                      lo_idx, hi_idx, win;
   logic                                  lo_any, hi_any;
   logic                                  load, grant;

   genvar k;
   generate
      for (k = 0; k < NUM_INPUTS; k++) begin : g_lane
         assign lane_data[k] = in_data[k*DATA_WIDTH +: DATA_WIDTH];
         arb_mux_lane #(.IDX(k), .SEL_W(SEL_W)) u_lane (
            .valid  (in_valid[k]),
            .ptr    (ptr),
            .win    (win),
            .grant  (grant),
            .hi_req (hi_req[k]),
            .ready  (in_ready[k])
         );
      end
   endgenerate

   // Two priority scans: lowest valid overall, and lowest valid at/above ptr.
   // Round-robin takes the upper scan when it hits, otherwise wraps to the
   // lower one; fixed priority always uses the lower one.
   always_comb begin
      lo_idx = '0;
      lo_any = 1'b0;
      hi_idx = '0;
      hi_any = 1'b0;
      for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
         if (in_valid[i]) begin
            lo_idx = SEL_W'(i);
            lo_any = 1'b1;
         end
         if (hi_req[i]) begin
            hi_idx = SEL_W'(i);
            hi_any = 1'b1;
         end
      end
      win = (ARB_MODE == 1 && hi_any) ? hi_idx : lo_idx;
   end

   assign load  = !out_valid || out_ready;
   assign grant = load && !rst && lo_any;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= '0;
         ptr       <= '0;
      end else if (load) begin
         if (lo_any) begin
            out_data  <= lane_data[win];
            out_sel   <= win;
            out_valid <= 1'b1;
            // Explicit wrap keeps ptr below NUM_INPUTS for non-power-of-2 sizes.
            if (ARB_MODE == 1) ptr <= (win == LAST) ? '0 : win + 1'b1;
         end else begin
            out_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_arb_mux.sv
// Bench for arb_mux: four instances (4-ch round-robin, 4-ch fixed priority,
// 3-ch round-robin, 1-ch) share stimulus and are compared every cycle against
// a behavioural model, with directed literal checks and a per-channel
// scoreboard on the 4-ch round-robin instance.
module tb_arb_mux;
   logic        clk;
   logic        rst;
   logic [31:0] id;
   logic [3:0]  iv;
   logic        ordy;

   logic [3:0] rdy0, rdy1;
   logic [2:0] rdy2;
   logic [0:0] rdy3;
   logic [7:0] od0, od1, od2, od3;
   logic       ov0, ov1, ov2, ov3;
   logic [1:0] os0, os1, os2;
   logic [0:0] os3;

   arb_mux #(.NUM_INPUTS(4), .DATA_WIDTH(8), .ARB_MODE(1)) u0 (
      .clk(clk), .rst(rst), .in_data(id), .in_valid(iv), .in_ready(rdy0),
      .out_data(od0), .out_valid(ov0), .out_ready(ordy), .out_sel(os0));
   arb_mux #(.NUM_INPUTS(4), .DATA_WIDTH(8), .ARB_MODE(0)) u1 (
      .clk(clk), .rst(rst), .in_data(id), .in_valid(iv), .in_ready(rdy1),
      .out_data(od1), .out_valid(ov1), .out_ready(ordy), .out_sel(os1));
   arb_mux #(.NUM_INPUTS(3), .DATA_WIDTH(8), .ARB_MODE(1)) u2 (
      .clk(clk), .rst(rst), .in_data(id[23:0]), .in_valid(iv[2:0]), .in_ready(rdy2),
      .out_data(od2), .out_valid(ov2), .out_ready(ordy), .out_sel(os2));
   arb_mux #(.NUM_INPUTS(1), .DATA_WIDTH(8), .ARB_MODE(1)) u3 (
      .clk(clk), .rst(rst), .in_data(id[7:0]), .in_valid(iv[0:0]), .in_ready(rdy3),
      .out_data(od3), .out_valid(ov3), .out_ready(ordy), .out_sel(os3));

   logic [3:0] rdy_a [4];
   logic [7:0] od_a  [4];
   logic       ov_a  [4];
   logic [1:0] os_a  [4];
   assign rdy_a[0] = rdy0;            assign rdy_a[1] = rdy1;
   assign rdy_a[2] = {1'b0, rdy2};    assign rdy_a[3] = {3'b0, rdy3};
   assign od_a[0] = od0; assign od_a[1] = od1; assign od_a[2] = od2; assign od_a[3] = od3;
   assign ov_a[0] = ov0; assign ov_a[1] = ov1; assign ov_a[2] = ov2; assign ov_a[3] = ov3;
   assign os_a[0] = os0; assign os_a[1] = os1; assign os_a[2] = os2; assign os_a[3] = {1'b0, os3};

   int cfg_n [4] = '{4, 4, 3, 1};
   int cfg_m [4] = '{1, 0, 1, 1};

   // Model state: output register contents and the round-robin start index.
   int  mv [4];
   int  md [4];
   int  ms [4];
   int  mp [4];
   bit  started;

   int total;
   int bad;
   int sbq [$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // First valid channel in scan order: from ptr with wrap (round-robin) or from 0.
   function automatic int winner(input int n, input int mode, input int ptr, input logic [3:0] v);
      for (int off = 0; off < n; off++) begin
         int c;
         c = mode ? (ptr + off) % n : off;
         if (v[c]) return c;
      end
      return -1;
   endfunction

   initial begin
      for (int i = 0; i < 4; i++) begin
         mv[i] = 0; md[i] = 0; ms[i] = 0; mp[i] = 0;
      end
      started = 1'b0;
   end

   // Model advance at each rising edge using the inputs that the DUT sees.
   always @(posedge clk) begin
      started = 1'b1;
      for (int i = 0; i < 4; i++) begin
         int w;
         if (rst) begin
            mv[i] = 0; md[i] = 0; ms[i] = 0; mp[i] = 0;
         end else if (mv[i] == 0 || ordy) begin
            w = winner(cfg_n[i], cfg_m[i], mp[i], iv);
            if (w >= 0) begin
               mv[i] = 1;
               md[i] = int'(id[w*8 +: 8]);
               ms[i] = w;
               if (cfg_m[i] != 0) mp[i] = (w + 1) % cfg_n[i];
            end else begin
               mv[i] = 0;
            end
         end
      end
   end

   // Compare process: all outputs checked mid-cycle, inputs stable.
   always @(negedge clk) begin
      if (started) begin
         for (int i = 0; i < 4; i++) begin
            int w;
            logic [3:0] er;
            w  = winner(cfg_n[i], cfg_m[i], mp[i], iv);
            er = 4'b0;
            if (!rst && (mv[i] == 0 || ordy) && w >= 0) er[w] = 1'b1;
            chk($sformatf("in_ready[u%0d]", i), int'(rdy_a[i]), int'(er));
            chk($sformatf("out_valid[u%0d]", i), int'(ov_a[i]), mv[i]);
            chk($sformatf("out_data[u%0d]", i), int'(od_a[i]), md[i]);
            chk($sformatf("out_sel[u%0d]", i), int'(os_a[i]), ms[i]);
         end
         chk("one_hot_u0", int'($countones(rdy0) <= 1), 1);
         if (rst) begin
            sbq.delete();
         end else begin
            if (ov0 && ordy) begin
               int idx;
               idx = -1;
               for (int j = 0; j < sbq.size(); j++)
                  if (idx < 0 && sbq[j] / 256 == int'(os0)) idx = j;
               if (idx < 0) begin
                  chk("sb_present", 0, 1);
               end else begin
                  chk("sb_data", int'(od0), sbq[idx] % 256);
                  sbq.delete(idx);
               end
            end
            for (int k = 0; k < 4; k++)
               if (rdy0[k] && iv[k]) sbq.push_back(k * 256 + int'(id[k*8 +: 8]));
         end
      end
   end

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      iv    = '0;
      id    = '0;
      ordy  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", int'(ov0), 0);
      chk("rst_data", int'(od0), 0);
      chk("rst_sel", int'(os0), 0);
      chk("rst_ready", int'(rdy0), 0);

      // All channels valid: round-robin rotates, fixed priority sticks at 0.
      rst  = 1'b0;
      iv   = 4'hF;
      id   = 32'h1312_1110;
      ordy = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         chk("rr4_sel", int'(os0), k % 4);
         chk("rr4_data", int'(od0), 'h10 + k % 4);
         chk("model_rr4_sel", ms[0], k % 4);
         chk("rr3_sel", int'(os2), k % 3);
         chk("rr3_data", int'(od2), 'h10 + k % 3);
         chk("fix_sel_all", int'(os1), 0);
         chk("one_sel", int'(os3), 0);
      end
      @(posedge clk); #1;
      chk("rr4_sel_ptr2", int'(os0), 1);

      // Reset with a word held and ptr at 2.
      rst = 1'b1;
      @(posedge clk); #1;
      chk("mid_rst_valid", int'(ov0), 0);
      chk("mid_rst_data", int'(od0), 0);
      chk("mid_rst_sel", int'(os0), 0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_sel", int'(os0), 0);
      chk("post_rst_data", int'(od0), 'h10);
      chk("model_post_rst", ms[0], 0);

      // Fixed priority starves channel 3.
      iv = 4'b1010;
      #1;
      chk("fix_ready", int'(rdy1), 'b0010);
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         chk("fix_sel", int'(os1), 1);
         chk("fix_data", int'(od1), 'h11);
         chk("fix_ready", int'(rdy1), 'b0010);
      end

      // Held output under backpressure, then same-edge replacement.
      iv = 4'b0100;
      id = 32'h13A5_1110;
      @(posedge clk); #1;
      chk("hold_first_sel", int'(os0), 2);
      chk("hold_first_data", int'(od0), 'hA5);
      ordy = 1'b0;
      iv   = 4'hF;
      id   = 32'hD3D2_D1D0;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         chk("hold_data", int'(od0), 'hA5);
         chk("hold_sel", int'(os0), 2);
         chk("hold_valid", int'(ov0), 1);
         chk("hold_ready", int'(rdy0), 0);
      end
      ordy = 1'b1;
      #1;
      chk("release_ready", int'(rdy0), 'b1000);
      @(posedge clk); #1;
      chk("release_sel", int'(os0), 3);
      chk("release_data", int'(od0), 'hD3);
      chk("release_valid", int'(ov0), 1);

      // Random traffic with occasional reset.
      repeat (10000) begin
         @(posedge clk); #2;
         rst  = ($urandom_range(0, 999) == 0);
         iv   = 4'($urandom);
         id   = $urandom;
         ordy = ($urandom_range(0, 3) != 0);
      end
      @(posedge clk); #2;
      rst = 1'b0;
      iv  = '0;
      repeat (3) @(posedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
